tqvp_reg_bus_arbiter: RTL and testbench

TQVP_REG_BUS_ARBITER -- requirements
Module: tqvp_reg_bus_arbiter

---
 rtl/tqvp_arb_pkg.sv | 30 +++
 rtl/tqvp_arb_timeout.sv | 26 ++
 rtl/tqvp_reg_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_tqvp_reg_bus_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_arb_pkg.sv
// Shared encodings, FSM state type and read-data width masking for the
// two-requester register bus arbiter.
package tqvp_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    localparam logic [1:0] TXN_BYTE = 2'b00;
    localparam logic [1:0] TXN_HALF = 2'b01;
    localparam logic [1:0] TXN_WORD = 2'b10;
    localparam logic [1:0] TXN_IDLE = 2'b11;

    localparam logic [DATA_W-1:0] ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    function automatic logic [DATA_W-1:0] width_mask(input logic [1:0]        width,
                                                     input logic [DATA_W-1:0] data);
        case (width)
            TXN_BYTE: width_mask = {24'h0, data[7:0]};
            TXN_HALF: width_mask = {16'h0, data[15:0]};
            default:  width_mask = data;
        endcase
    endfunction

endpackage

// File: rtl/tqvp_arb_timeout.sv
// Read-wait timeout counter: load starts the count at the first ISSUE cycle,
// expired flags that the configured number of ISSUE cycles has been reached.
module tqvp_arb_timeout (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       count,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'd1;
        end else if (count) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt == limit);

endmodule

// File: rtl/tqvp_reg_bus_arbiter.sv
// Round-robin arbiter sharing one register bus between two requesters.
// Define TQVP_ARB_TIMEOUT_EN to abort reads after TIMEOUT_CYCLES ISSUE cycles.
module tqvp_reg_bus_arbiter
    import tqvp_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  req0_address,
    input  logic [31:0] req0_data_in,
    input  logic [1:0]  req0_write_n,
    input  logic [1:0]  req0_read_n,
    output logic [31:0] req0_data_out,
    output logic        req0_ready,
    output logic        req0_err,
    input  logic [5:0]  req1_address,
    input  logic [31:0] req1_data_in,
    input  logic [1:0]  req1_write_n,
    input  logic [1:0]  req1_read_n,
    output logic [31:0] req1_data_out,
    output logic        req1_ready,
    output logic        req1_err,
    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

    arb_state_t        state, state_nxt;
    logic [1:0]        req_active;
    logic              any_req;
    logic              grant_sel, grant, last_grant;
    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_data;
    logic              sel_write;
    logic [1:0]        sel_width;
    logic              lat_write;
    logic [1:0]        lat_width;
    logic              timeout, issue_done;

    logic [ADDR_W-1:0] address_d;
    logic [DATA_W-1:0] data_in_d;
    logic [1:0]        data_write_n_d, data_read_n_d;
    logic [1:0]        ready_d, ready_q, err_d, err_q;
    logic [DATA_W-1:0] rdata_d [2];
    logic [DATA_W-1:0] rdata_q [2];

    // Request decode and round-robin pick; writes take priority over reads.
    always_comb begin
        req_active[0] = (req0_write_n != TXN_IDLE) || (req0_read_n != TXN_IDLE);
        req_active[1] = (req1_write_n != TXN_IDLE) || (req1_read_n != TXN_IDLE);
        any_req       = |req_active;
        grant_sel     = (&req_active) ? ~last_grant : req_active[1];
        if (grant_sel) begin
            sel_address = req1_address;
            sel_data    = req1_data_in;
            sel_write   = (req1_write_n != TXN_IDLE);
            sel_width   = sel_write ? req1_write_n : req1_read_n;
        end else begin
            sel_address = req0_address;
            sel_data    = req0_data_in;
            sel_write   = (req0_write_n != TXN_IDLE);
            sel_width   = sel_write ? req0_write_n : req0_read_n;
        end
    end

`ifdef TQVP_ARB_TIMEOUT_EN
    logic tmo_load, tmo_count, tmo_expired;

    assign tmo_load  = (state == ST_IDLE) && any_req && !sel_write;
    assign tmo_count = (state == ST_ISSUE) && !lat_write;

    tqvp_arb_timeout u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (tmo_load),
        .count   (tmo_count),
        .limit   (8'(TIMEOUT_CYCLES)),
        .expired (tmo_expired)
    );

    // data_ready on the final counted cycle still completes normally.
    assign timeout = tmo_count && !data_ready && tmo_expired;
`else
    assign timeout = 1'b0;
`endif

    assign issue_done = lat_write || data_ready || timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: if (issue_done) state_nxt = ST_RESP;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        address_d      = address;
        data_in_d      = data_in;
        data_write_n_d = TXN_IDLE;
        data_read_n_d  = TXN_IDLE;
        ready_d        = 2'b00;
        err_d          = 2'b00;
        rdata_d[0]     = '0;
        rdata_d[1]     = '0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    address_d = sel_address;
                    data_in_d = sel_data;
                    if (sel_write) data_write_n_d = sel_width;
                    else           data_read_n_d  = sel_width;
                end
            end
            ST_ISSUE: begin
                if (!issue_done) begin
                    data_read_n_d = lat_width;
                end else begin
                    ready_d[grant] = 1'b1;
                    err_d[grant]   = timeout;
                    if (!lat_write)
                        rdata_d[grant] = width_mask(lat_width, timeout ? ERR_DATA : data_out);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            lat_write    <= 1'b0;
            lat_width    <= TXN_IDLE;
            address      <= '0;
            data_in      <= '0;
            data_write_n <= TXN_IDLE;
            data_read_n  <= TXN_IDLE;
            ready_q      <= 2'b00;
            err_q        <= 2'b00;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
        end else begin
            if (state == ST_IDLE && any_req) begin
                grant     <= grant_sel;
                lat_write <= sel_write;
                lat_width <= sel_width;
            end
            if (state == ST_RESP) last_grant <= grant;
            address      <= address_d;
            data_in      <= data_in_d;
            data_write_n <= data_write_n_d;
            data_read_n  <= data_read_n_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            rdata_q[0]   <= rdata_d[0];
            rdata_q[1]   <= rdata_d[1];
        end
    end

    assign req0_ready    = ready_q[0];
    assign req1_ready    = ready_q[1];
    assign req0_err      = err_q[0];
    assign req1_err      = err_q[1];
    assign req0_data_out = rdata_q[0];
    assign req1_data_out = rdata_q[1];

endmodule

// File: tb/tb_tqvp_reg_bus_arbiter.sv
// Directed bench for tqvp_reg_bus_arbiter; timeout checks follow TQVP_ARB_TIMEOUT_EN.
module tb_tqvp_reg_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  req0_address, req1_address, address;
    logic [31:0] req0_data_in, req1_data_in, data_in;
    logic [1:0]  req0_write_n, req0_read_n, req1_write_n, req1_read_n;
    logic [31:0] req0_data_out, req1_data_out, data_out;
    logic        req0_ready, req0_err, req1_ready, req1_err;
    logic [1:0]  data_write_n, data_read_n;
    logic        data_ready;

    int n_checks = 0;
    int n_errors = 0;

    tqvp_reg_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_address  (req0_address),
        .req0_data_in  (req0_data_in),
        .req0_write_n  (req0_write_n),
        .req0_read_n   (req0_read_n),
        .req0_data_out (req0_data_out),
        .req0_ready    (req0_ready),
        .req0_err      (req0_err),
        .req1_address  (req1_address),
        .req1_data_in  (req1_data_in),
        .req1_write_n  (req1_write_n),
        .req1_read_n   (req1_read_n),
        .req1_data_out (req1_data_out),
        .req1_ready    (req1_ready),
        .req1_err      (req1_err),
        .address       (address),
        .data_in       (data_in),
        .data_write_n  (data_write_n),
        .data_read_n   (data_read_n),
        .data_out      (data_out),
        .data_ready    (data_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [5:0] a, input logic [31:0] d,
                           input logic [1:0] wr, input logic [1:0] rd);
        if (idx == 0) begin
            req0_address = a; req0_data_in = d; req0_write_n = wr; req0_read_n = rd;
        end else begin
            req1_address = a; req1_data_in = d; req1_write_n = wr; req1_read_n = rd;
        end
    endtask

    task automatic drop(input int idx);
        set_req(idx, 6'h00, 32'h0, 2'b11, 2'b11);
    endtask

    // Entered in the IDLE cycle where requester idx is (or will be) granted.
    task automatic serve_write(input int idx, input logic [5:0] a, input logic [31:0] d,
                               input string tag);
        tick();
        check({tag, ".strobe"},  32'(data_write_n), 32'h2);
        check({tag, ".address"}, 32'(address), 32'(a));
        check({tag, ".data_in"}, data_in, d);
        check({tag, ".read_n"},  32'(data_read_n), 32'h3);
        tick();
        check({tag, ".ready"},   32'(idx == 0 ? req0_ready : req1_ready), 32'h1);
        check({tag, ".other"},   32'(idx == 0 ? req1_ready : req0_ready), 32'h0);
        check({tag, ".rdata"},   idx == 0 ? req0_data_out : req1_data_out, 32'h0);
        check({tag, ".idle_wr"}, 32'(data_write_n), 32'h3);
        drop(idx);
        tick();
        check({tag, ".ready_off"}, 32'(idx == 0 ? req0_ready : req1_ready), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; data_ready = 1'b0; data_out = 32'h0;
        drop(0); drop(1);
        tick(); tick();
        check("rst.write_n", 32'(data_write_n), 32'h3);
        check("rst.read_n",  32'(data_read_n), 32'h3);
        check("rst.address", 32'(address), 32'h0);
        check("rst.data_in", data_in, 32'h0);
        check("rst.ready",   32'({req1_ready, req0_ready}), 32'h0);
        check("rst.err",     32'({req1_err, req0_err}), 32'h0);
        check("rst.rdata0",  req0_data_out, 32'h0);
        rst = 1'b0;

        data_ready = 1'b1; data_out = 32'hDEADBEEF;
        tick();
        check("ign.ready", 32'({req1_ready, req0_ready}), 32'h0);
        check("ign.rdata", req0_data_out | req1_data_out, 32'h0);
        data_ready = 1'b0;

        set_req(0, 6'h04, 32'h12345678, 2'b10, 2'b11);
        serve_write(0, 6'h04, 32'h12345678, "wr0");
        check("wr0.hold_addr", 32'(address), 32'h4);

        set_req(1, 6'h10, 32'h0, 2'b11, 2'b00);
        tick();
        check("rd1.read_n",  32'(data_read_n), 32'h0);
        check("rd1.address", 32'(address), 32'h10);
        check("rd1.write_n", 32'(data_write_n), 32'h3);
        tick(); tick();
        check("rd1.wait_read_n", 32'(data_read_n), 32'h0);
        check("rd1.wait_ready",  32'(req1_ready), 32'h0);
        tick();
        data_ready = 1'b1; data_out = 32'hAABBCCDD;
        tick();
        check("rd1.ready",  32'(req1_ready), 32'h1);
        check("rd1.rdata",  req1_data_out, 32'h000000DD);
        check("rd1.err",    32'(req1_err), 32'h0);
        check("rd1.done_n", 32'(data_read_n), 32'h3);
        check("rd1.other",  32'(req0_ready), 32'h0);
        drop(1); data_ready = 1'b0;
        tick();
        check("rd1.ready_off", 32'(req1_ready), 32'h0);
        check("rd1.rdata_off", req1_data_out, 32'h0);

        rst = 1'b1; tick(); rst = 1'b0;
        set_req(0, 6'h01, 32'h11111111, 2'b10, 2'b11);
        set_req(1, 6'h02, 32'h22222222, 2'b10, 2'b11);
        serve_write(0, 6'h01, 32'h11111111, "rr1.a");
        serve_write(1, 6'h02, 32'h22222222, "rr1.b");
        set_req(0, 6'h05, 32'h33333333, 2'b10, 2'b11);
        set_req(1, 6'h06, 32'h44444444, 2'b10, 2'b11);
        serve_write(0, 6'h05, 32'h33333333, "rr2.a");
        serve_write(1, 6'h06, 32'h44444444, "rr2.b");
        set_req(0, 6'h07, 32'h55555555, 2'b10, 2'b11);
        serve_write(0, 6'h07, 32'h55555555, "sole.a");
        set_req(0, 6'h08, 32'h66666666, 2'b10, 2'b11);
        serve_write(0, 6'h08, 32'h66666666, "sole.b");
        set_req(0, 6'h09, 32'h77777777, 2'b10, 2'b11);
        set_req(1, 6'h0A, 32'h88888888, 2'b10, 2'b11);
        serve_write(1, 6'h0A, 32'h88888888, "rr3.a");
        serve_write(0, 6'h09, 32'h77777777, "rr3.b");

        set_req(0, 6'h08, 32'h0, 2'b11, 2'b01);
`ifdef TQVP_ARB_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("tmo.read_n", 32'(data_read_n), 32'h1);
            check("tmo.wait",   32'(req0_ready), 32'h0);
        end
        tick();
        check("tmo.ready",  32'(req0_ready), 32'h1);
        check("tmo.err",    32'(req0_err), 32'h1);
        check("tmo.rdata",  req0_data_out, 32'h0000FFFF);
        check("tmo.done_n", 32'(data_read_n), 32'h3);
        drop(0);
        tick();
        check("tmo.off", 32'({req0_err, req0_ready}), 32'h0);
        set_req(0, 6'h08, 32'h0, 2'b11, 2'b00);
        tick(); tick(); tick(); tick();
        data_ready = 1'b1; data_out = 32'h5A5A5A77;
        tick();
        check("last.ready", 32'(req0_ready), 32'h1);
        check("last.err",   32'(req0_err), 32'h0);
        check("last.rdata", req0_data_out, 32'h00000077);
        drop(0); data_ready = 1'b0;
        tick();
`else
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("wait.err", 32'({req0_err, req0_ready}), 32'h0);
        end
        check("wait.read_n", 32'(data_read_n), 32'h1);
        data_ready = 1'b1; data_out = 32'h1234ABCD;
        tick();
        check("wait.ready", 32'(req0_ready), 32'h1);
        check("wait.nerr",  32'(req0_err), 32'h0);
        check("wait.rdata", req0_data_out, 32'h0000ABCD);
        drop(0); data_ready = 1'b0;
        tick();
`endif

        set_req(1, 6'h20, 32'h0, 2'b11, 2'b10);
        tick();
        check("rsti.read_n", 32'(data_read_n), 32'h2);
        rst = 1'b1;
        tick();
        check("rsti.abort_n", 32'(data_read_n), 32'h3);
        check("rsti.ready",   32'({req1_err, req1_ready}), 32'h0);
        check("rsti.address", 32'(address), 32'h0);
        rst = 1'b0; drop(1);
        tick();
        check("rsti.no_ready", 32'({req1_err, req1_ready}), 32'h0);
        set_req(0, 6'h2A, 32'hCAFEBABE, 2'b10, 2'b11);
        serve_write(0, 6'h2A, 32'hCAFEBABE, "rsti.wr");

        set_req(0, 6'h03, 32'h0, 2'b11, 2'b10);
        tick();
        check("fast.read_n", 32'(data_read_n), 32'h2);
        data_ready = 1'b1; data_out = 32'hCAFEF00D;
        tick();
        check("fast.ready",  32'(req0_ready), 32'h1);
        check("fast.rdata",  req0_data_out, 32'hCAFEF00D);
        check("fast.done_n", 32'(data_read_n), 32'h3);
        drop(0); data_ready = 1'b0;
        tick();
        check("fast.off", 32'(req0_ready), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
